// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder (spi_slave_port).
package spi_pkg;

  // FSM encoding: idle between frames, shifting while cs_n is low.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DATA_W = 8;

  localparam logic [SPI_DATA_W-1:0] SPI_DEFAULT_TX = '0;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser with one extra flop for rise/fall detection.
// RESET_VAL sets the idle level of the whole chain so reset produces no edges.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q;

  // Shift the raw pin into the chain.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  // Chain and edge-detect flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign q    = chain_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder, MSB first, oversampled in the system clock domain.
// Optional macro SPI_SLAVE_UNDERRUN_EN adds the tx_underrun pulse output.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = SPI_DATA_W,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'(SPI_DEFAULT_TX),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic              tx_underrun
`endif
);

  localparam int unsigned      CntW   = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q;
  logic unused_sclk_q, unused_mosi_rise, unused_mosi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .d     (sclk),
    .q     (unused_sclk_q),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clock (clock),
    .reset (reset),
    .d     (cs_n),
    .q     (cs_q),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clock (clock),
    .reset (reset),
    .d     (mosi),
    .q     (mosi_q),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  spi_state_e           state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]    rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]    hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 miso_q, miso_d;
  logic [SYNC_STAGES:0] flush_q, flush_d;
  logic                 armed_q, armed_d;

  logic              load;
  logic              accept;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] assembled;

  assign accept    = tx_valid & ~hold_full_q;
  assign load_word = hold_full_q ? hold_q : DEFAULT_TX;
  assign assembled = {rx_sr_q, mosi_q};

  // Next-state: frame FSM, shift registers, holding register handshake.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    load        = 1'b0;
    // The synchroniser reset values look like a cs_n fall if the pin is low
    // at reset release; only arm once a genuine high level has been sampled.
    flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (flush_q[SYNC_STAGES] & cs_q);

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (cs_fall && armed_q) begin
          load    = 1'b1;
          tx_sr_d = load_word;
          miso_d  = load_word[DATA_W-1];
          rx_sr_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cs_n rise wins over any coincident sclk edge.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d = assembled[DATA_W-2:0];
          if (bit_cnt_q == CntMax) begin
            bit_cnt_d  = '0;
            rx_data_d  = assembled;
            rx_valid_d = 1'b1;
            load       = 1'b1;
            tx_sr_d    = load_word;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // bit_cnt of 0 here means the word boundary: present the fresh MSB.
          if (bit_cnt_q == '0) begin
            miso_d = tx_sr_q[DATA_W-1];
          end else begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            miso_d  = tx_sr_q[DATA_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load consumes the old content before a same-cycle accept refills it.
    if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign miso     = miso_q;
  assign miso_en  = ~cs_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  // Pulse when a load falls back to DEFAULT_TX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= load & ~hold_full_q;
    end
  end

  assign tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: SPI initiator model, holding-slot reference model,
// and scoreboards for received words and words captured from miso.
module tb_spi_slave_port;

  logic       clock, reset, sclk, cs_n, mosi;
  logic       miso, miso_en, tx_valid, tx_ready, rx_valid;
  logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  spi_slave_port dut (
    .clock    (clock),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_en  (miso_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
`ifdef SPI_SLAVE_UNDERRUN_EN
    .tx_underrun (tx_underrun),
`endif
    .rx_valid (rx_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];

  // Reference model: a single holding slot, emptied by every word start.
  logic       model_full = 1'b0;
  logic [7:0] model_hold = 8'h00;
  int         exp_underrun = 0;
  int         seen_underrun = 0;
  logic       miso_chk_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_take();
    if (model_full) begin
      model_full = 1'b0;
      return model_hold;
    end
    exp_underrun++;
    return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic offer(input logic [7:0] w);
    tx_valid = 1'b1;
    tx_data  = w;
    @(posedge clock);
    if (!model_full) begin
      model_full = 1'b1;
      model_hold = w;
    end
    #2;
    tx_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int half);
    mosi = b;
    wait_clk(half);
    sclk = 1'b1;
    wait_clk(half);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] words [4], input int n, input int half);
    logic [7:0] exp;
    cs_n = 1'b0;
    for (int w = 0; w < n; w++) begin
      exp = model_take();
      rx_q.push_back(words[w]);
      if (miso_chk_en) miso_q.push_back(exp);
      for (int b = 7; b >= 0; b--) send_bit(words[w][b], half);
    end
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Monitor: every rx_valid pulse must match the next expected received word.
  always @(negedge clock) begin
    if (reset && rx_valid) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected_valid", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        check("rx_word", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
`ifdef SPI_SLAVE_UNDERRUN_EN
    if (reset && tx_underrun) seen_underrun++;
`endif
  end

  // Monitor: initiator-side capture of miso on sclk rise, whole words only.
  logic [7:0] mword = 8'h00;
  int         mcnt = 0;
  always @(posedge sclk or posedge cs_n or negedge reset) begin
    if (!reset || cs_n) begin
      mcnt  = 0;
      mword = 8'h00;
    end else if (miso_chk_en) begin
      mword = {mword[6:0], miso};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (miso_q.size() == 0) check("miso_unexpected_word", 32'(mword), 32'hFFFF_FFFF);
        else check("miso_word", 32'(mword), 32'(miso_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [4];
    logic [7:0] dummy;
    int         n;

    reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_tx_ready", 32'(tx_ready), 1);
    check("reset_miso", 32'(miso), 0);
    check("reset_miso_en", 32'(miso_en), 0);
    reset = 1'b1;
    wait_clk(10);

    // Queued 0xA5 out while 0x3C comes in.
    offer(8'hA5);
    check("tx_ready_after_accept", 32'(tx_ready), 0);
    words[0] = 8'h3C;
    send_frame(words, 1, 5);
    check("tx_ready_after_load", 32'(tx_ready), 1);
    check("rx_data_hold_3c", 32'(rx_data), 32'h3C);

    // Two-word frame with only one word queued.
    offer(8'h81);
    words[0] = 8'h12; words[1] = 8'h34;
    send_frame(words, 2, 5);

    // Aborted frame after 5 bits of 0xFF, then a clean 0x5A.
    cs_n = 1'b0;
    dummy = model_take();
    for (int b = 0; b < 5; b++) send_bit(1'b1, 5);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(8);
    words[0] = 8'h5A;
    send_frame(words, 1, 5);
    check("rx_data_after_abort", 32'(rx_data), 32'h5A);

    // Reset mid-frame with cs_n held low, then ignore until a fresh frame.
    miso_chk_en = 1'b0;
    cs_n = 1'b0;
    dummy = model_take();
    for (int b = 0; b < 3; b++) send_bit(1'($urandom_range(0, 1)), 5);
    reset = 1'b0;
    model_full = 1'b0;
    wait_clk(2);
    check("midreset_rx_data", 32'(rx_data), 0);
    check("midreset_rx_valid", 32'(rx_valid), 0);
    check("midreset_tx_ready", 32'(tx_ready), 1);
    check("midreset_miso", 32'(miso), 0);
    check("midreset_miso_en", 32'(miso_en), 0);
    reset = 1'b1;
    wait_clk(4);
    for (int b = 0; b < 4; b++) begin
      send_bit(1'b1, 5);
      check("ignored_miso", 32'(miso), 0);
      check("ignored_miso_en", 32'(miso_en), 1);
    end
    cs_n = 1'b1;
    wait_clk(10);
    miso_chk_en = 1'b1;
    words[0] = 8'hC3;
    send_frame(words, 1, 5);
    check("rx_data_after_reset", 32'(rx_data), 32'hC3);

    // Back-to-back offers: the second is ignored while the slot is full.
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    @(posedge clock);
    if (!model_full) begin model_full = 1'b1; model_hold = 8'h11; end
    #2;
    tx_data = 8'h22;
    @(posedge clock);
    if (!model_full) begin model_full = 1'b1; model_hold = 8'h22; end
    #1;
    check("tx_ready_low_held", 32'(tx_ready), 0);
    #1;
    tx_valid = 1'b0;
    wait_clk(2);
    words[0] = 8'($urandom);
    send_frame(words, 1, 5);

    // Randomised frames with random queued words.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      n = $urandom_range(1, 3);
      for (int w = 0; w < 4; w++) words[w] = 8'($urandom);
      send_frame(words, n, 5);
    end

    // sclk at a quarter of the system clock; miso is not valid this fast.
    miso_chk_en = 1'b0;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h00; words[3] = 8'hFF;
    send_frame(words, 4, 2);
    miso_chk_en = 1'b1;

    wait_clk(20);
    check("rx_queue_drained", 32'(rx_q.size()), 0);
    check("miso_queue_drained", 32'(miso_q.size()), 0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("underrun_count", 32'(seen_underrun), 32'(exp_underrun));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the router's external SPI link; the answering end to the SPI initiator.
- Oversamples sclk/cs_n/mosi in the system clock domain, deserialises received words to a valid pulse, and serialises queued transmit words onto miso.
- Sits between the SPI pins and the router's packet buffer logic.

Parameters:
- DATA_W, 8, word width in bits; also the bits per transfer before wrap.
- DEFAULT_TX, 0 (DATA_W bits), word shifted out when no transmit word is queued.
- SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and mosi (minimum 2).

Ports:
- clock  input  1  system clock; must be at least 4x the sclk frequency.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from the initiator.
- cs_n  input  1  SPI chip select, active-low.
- mosi  input  1  serial data in.
- miso  output  1  serial data out.
- miso_en  output  1  high while the synchronised cs_n is low; pad output-enable.
- tx_data  input  DATA_W  word to transmit.
- tx_valid  input  1  tx_data is offered.
- tx_ready  output  1  transmit holding register is empty.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 except tx_ready=1.
  - Synchroniser reset values: cs_n chain to 1, sclk and mosi chains to 0.
  - FSM goes to IDLE; bit counter, shift registers and holding register are cleared.
- Synchronisation: each input passes through SYNC_STAGES flops, plus one more flop for edge detection.
  - Pin edge to internal action latency is SYNC_STAGES+1 clocks (3 by default).
- Transmit handshake:
  - A word is accepted when tx_valid && tx_ready; tx_ready drops the next cycle.
  - tx_valid while tx_ready=0 is ignored; the held word is not overwritten.
  - tx_ready returns to 1 on the cycle the holding register is moved into the tx shift register.
- FSM, IDLE:
  - miso=0, bit_cnt=0.
  - On a cs_n falling-edge detect: load the tx shift register from the holding register if it is full, else from DEFAULT_TX.
  - miso is driven with the MSB of the loaded word on that same cycle; go to SHIFT.
- FSM, SHIFT:
  - sclk rising detect: rx shift register <= {rx_sr[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - sclk falling detect: tx shift register shifts left and miso = its new MSB, except on the word-boundary fall.
  - Word boundary: when bit_cnt wraps (DATA_W-1 to 0) on a rising edge:
    - rx_data <= assembled word and rx_valid pulses for exactly 1 cycle.
    - The tx shift register reloads (holding register or DEFAULT_TX).
    - miso takes the new MSB on the following sclk fall.
  - A frame continues across multiple words for as long as cs_n stays low.
  - cs_n rising detect: go to IDLE. A partial word is discarded (no rx_valid) and bit_cnt clears.
- Simultaneous events:
  - A cs_n rise and an sclk rise detected on the same cycle: cs_n wins, and the bit is not counted.
  - Word-boundary reload and tx_valid handshake on the same cycle: the reload uses the old holding content. The new word is captured and stays held.
- Reset released while cs_n is low: stay in IDLE until cs_n is seen high and then falls (no mid-frame joining).
- bit_cnt width is $clog2(DATA_W); it wraps modulo DATA_W.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined: adds output tx_underrun (1 bit, reset 0).
  - It pulses for 1 cycle whenever a tx shift register load (frame start or word boundary) uses DEFAULT_TX because the holding register is empty.
- Undefined: port and logic are absent; DEFAULT_TX substitution is unchanged.

Decomposition:
- Package spi_pkg holds:
  - state constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - default DATA_W=8;
  - default DEFAULT_TX=0.
- Sub-module spi_sync: a SYNC_STAGES-deep synchroniser with rise/fall detect outputs and a parameterised reset value.
  - Instantiated for sclk (reset 0), cs_n (reset 1) and mosi (reset 0; edge outputs unused).

Test Plan (clock 100 MHz, sclk 10 MHz, DATA_W=8):
- Queue tx 0xA5, initiator sends 0x3C in one frame -> rx_data=0x3C with a single rx_valid pulse; initiator captures 0xA5; tx_ready=1 after load.
- Queue 0x81 only, 2-word frame sending 0x12 then 0x34 -> rx_valid twice (0x12, 0x34); miso words are 0x81 then 0x00; tx_underrun pulses once if enabled.
- cs_n rises after 5 bits of 0xFF, then a new frame sends 0x5A -> no rx_valid for the aborted word; rx_data=0x5A, correctly aligned.
- reset=0 after 3 bits with cs_n held low, then released -> outputs 0, tx_ready=1; further sclk ignored until cs_n high then low; next 0xC3 is received correctly.
- tx_valid with 0x11 then 0x22 in consecutive cycles during IDLE -> tx_ready low after 0x11; 0x22 is ignored; the next frame transmits 0x11.
- sclk 4x slower than clock (25 MHz) back-to-back 0x00/0xFF words -> no missed or extra bits; rx matches.
